// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS E-stage multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic        md_wr,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] md_out
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_start, w_done, w_signed, w_is_div, w_neg_q, w_neg_r, w_div0;
  logic [31:0] w_abs_a, w_abs_b, w_den, w_q, w_r, w_res_hi, w_res_lo;
  logic [63:0] w_prod;

  assign w_start = md_start & ~md_op[2] & (r_state == IDLE);
  assign w_done  = (r_state == RUN) & (r_cnt == '0);
  assign busy    = w_start | (r_state == RUN);
  assign md_out  = rd_hi ? r_hi : r_lo;

  assign w_signed = ~r_op[0];
  assign w_is_div = r_op[1];
  assign w_div0   = w_is_div & (r_b == '0);
  assign w_prod   = w_signed ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                             : ({32'd0, r_a} * {32'd0, r_b});

  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
  assign w_neg_q  = w_signed & (r_a[31] ^ r_b[31]);
  assign w_neg_r  = w_signed & r_a[31];
  assign w_abs_a  = (w_signed & r_a[31]) ? -r_a : r_a;
  assign w_abs_b  = (w_signed & r_b[31]) ? -r_b : r_b;
  assign w_den    = (r_b == '0) ? 32'd1 : w_abs_b;
  assign w_q      = w_abs_a / w_den;
  assign w_r      = w_abs_a % w_den;
  assign w_res_lo = w_is_div ? (w_neg_q ? -w_q : w_q) : w_prod[31:0];
  assign w_res_hi = w_is_div ? (w_neg_r ? -w_r : w_r) : w_prod[63:32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (md_wr & ~md_start) begin
        if (md_op == 3'd4) r_hi <= rs_val;
        else if (md_op == 3'd5) r_lo <= rs_val;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op    <= md_op[1:0];
            r_a     <= rs_val;
            r_b     <= rt_val;
            r_cnt   <= md_op[1] ? DIV_LAST : MULT_LAST;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Completion is placed after the mthi/mtlo write so it wins on a same-edge collision
          if (w_done) begin
            if (!w_div0) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        md_start = 1'b0;
  logic        md_wr = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .md_start(md_start), .md_wr(md_wr), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .rd_hi(rd_hi), .busy(busy), .md_out(md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    rd_hi = 1'b1; #1; chk({tag, "_hi"}, md_out, hi);
    rd_hi = 1'b0; #1; chk({tag, "_lo"}, md_out, lo);
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint sa, sb;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = ua * ub;
      3'd2: r = (b == 0) ? old : {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = (b == 0) ? old : {32'(ua % ub), 32'(ua / ub)};
      default: r = old;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chain);
    int n;
    logic [63:0] nx;
    n = (op < 3'd2) ? MC : DC;
    nx = ref_md(op, a, b, {m_hi, m_lo});
    md_start = 1'b1; md_op = op; rs_val = a; rt_val = b; rd_hi = 1'($urandom);
    @(negedge clk);
    chk("busy_start", 32'(busy), 32'd1);
    chk("out_start", md_out, rd_hi ? m_hi : m_lo);
    cyc();
    md_start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    for (int k = 1; k <= n; k++) begin
      rd_hi = 1'($urandom);
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("out_run", md_out, rd_hi ? m_hi : m_lo);
      cyc();
    end
    {m_hi, m_lo} = nx;
    if (!chain) begin
      @(negedge clk);
      chk("busy_done", 32'(busy), 32'd0);
      chk_hl("result", m_hi, m_lo);
      cyc();
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    md_wr = 1'b1; md_op = op; rs_val = v;
    cyc();
    md_wr = 1'b0;
    if (op == 3'd4) m_hi = v;
    else m_lo = v;
    @(negedge clk);
    chk("mt_busy", 32'(busy), 32'd0);
    chk_hl("mt", m_hi, m_lo);
    cyc();
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          chain;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_hl("rst", 32'd0, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk_hl("multu", 32'h00000002, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'd3, 32'd7, 32'd2, 1'b0);
    chk_hl("divu", 32'd1, 32'd3);
    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    run_op(3'd2, $urandom, 32'd0, 1'b0);
    chk_hl("div0", 32'h11, 32'h22);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk_hl("div_ovf", 32'd0, 32'h80000000);

    // mthi lands mid-run, mtlo collides with the completion edge
    md_start = 1'b1; md_op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
    cyc();
    md_start = 1'b0; md_wr = 1'b1; md_op = 3'd4; rs_val = 32'hAAAA;
    cyc();
    md_wr = 1'b0; rd_hi = 1'b1;
    @(negedge clk);
    chk("mthi_run", md_out, 32'hAAAA);
    chk("mthi_busy", 32'(busy), 32'd1);
    cyc();
    cyc();
    cyc();
    md_wr = 1'b1; md_op = 3'd5; rs_val = 32'h55;
    cyc();
    md_wr = 1'b0;
    @(negedge clk);
    chk("mthi_done_busy", 32'(busy), 32'd0);
    chk_hl("mthi_done", 32'd0, 32'd6);
    m_hi = 32'd0; m_lo = 32'd6;
    cyc();

    // md_start held through RUN with changing operands
    md_start = 1'b1; md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd9;
    cyc();
    for (int k = 1; k <= MC; k++) begin
      md_op = 3'($urandom_range(0, 3)); rs_val = $urandom; rt_val = $urandom;
      @(negedge clk);
      chk("held_busy", 32'(busy), 32'd1);
      cyc();
    end
    md_start = 1'b0;
    @(negedge clk);
    chk("held_busy_end", 32'(busy), 32'd0);
    chk_hl("held", 32'd0, 32'd63);
    m_hi = 32'd0; m_lo = 32'd63;
    cyc();

    run_op(3'd0, 32'd5, 32'd6, 1'b1);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    chk_hl("b2b", 32'd2, 32'd14);

    md_start = 1'b1; md_op = 3'd6; rs_val = 32'h1234; rt_val = 32'd1;
    @(negedge clk);
    chk("rsvd_busy", 32'(busy), 32'd0);
    cyc();
    md_start = 1'b0; md_wr = 1'b1; md_op = 3'd7;
    cyc();
    md_wr = 1'b0;
    @(negedge clk);
    chk("rsvd_busy2", 32'(busy), 32'd0);
    chk_hl("rsvd", m_hi, m_lo);
    cyc();

    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) a = -a;
      chain = (i < 11) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) mt(3'($urandom_range(4, 5)), $urandom);
      run_op(op, a, b, chain);
    end

    // Asynchronous reset mid-division must abort with no late write
    mt(3'd4, 32'h1234);
    mt(3'd5, 32'h5678);
    md_start = 1'b1; md_op = 3'd2; rs_val = $urandom | 32'd1; rt_val = 32'd3;
    cyc();
    md_start = 1'b0;
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    rd_hi = 1'b1; #0.5; chk("abort_hi_now", md_out, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_hold_busy", 32'(busy), 32'd0);
    chk_hl("abort_hold", 32'd0, 32'd0);
    cyc();
    reset_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (12) cyc();
    @(negedge clk);
    chk("abort_after_busy", 32'(busy), 32'd0);
    chk_hl("abort_after", 32'd0, 32'd0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
